// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and width helper for the scanning mux
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    // A single-channel-index field still needs one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// rtl/mux_scan_n_if.sv - channel data, select/mode/enable and sampled outputs
interface mux_scan_n_if #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = 3
) ();
    logic [N_CH*W-1:0] i;
    logic [SEL_W-1:0]  s;
    logic              mode;
    logic              en;
    logic [W-1:0]      y;
    logic [SEL_W-1:0]  ch;
    logic              valid;
    logic              sel_err;
    logic              wrap;

    modport master (output i, s, mode, en, input y, ch, valid, sel_err, wrap);
    modport slave  (input i, s, mode, en, output y, ch, valid, sel_err, wrap);
endinterface

// File: rtl/mux_scan_n_scan_ctr.sv
// rtl/mux_scan_n_scan_ctr.sv - dwell counter plus wrapping channel pointer
module scan_ctr
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DWELL = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [SEL_W-1:0] ptr,
    output logic             wrap_next
);
    localparam int DC_W = $clog2(DWELL + 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_CH - 1);

    logic [DC_W-1:0]  dc_q, dc_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             dc_last;

    assign dc_last   = (dc_q == DC_LAST);
    // Asserted when the coming edge moves the pointer from the last channel to 0.
    assign wrap_next = adv && dc_last && (ptr_q == PTR_LAST);
    assign ptr       = ptr_q;

    always_comb begin
        dc_d  = dc_q;
        ptr_d = ptr_q;
        if (clr) begin
            dc_d  = '0;
            ptr_d = '0;
        end else if (adv) begin
            if (dc_last) begin
                dc_d  = '0;
                ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + SEL_W'(1);
            end else begin
                dc_d = dc_q + DC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_q  <= '0;
            ptr_q <= '0;
        end else begin
            dc_q  <= dc_d;
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with manual select and auto-scan
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input logic         clk,
    input logic         rst,
    mux_scan_n_if.slave bus
);
    logic [SEL_W-1:0] ptr;
    logic             wrap_next;
    logic             clr, adv;

    logic [W-1:0]     y_q, y_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             sel_err_q, sel_err_d;
    logic             wrap_q, wrap_d;

    assign clr = bus.en && (bus.mode == MODE_MANUAL);
    assign adv = bus.en && (bus.mode == MODE_AUTO);

    scan_ctr #(.N_CH(N_CH), .DWELL(DWELL), .SEL_W(SEL_W)) u_scan_ctr (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .adv       (adv),
        .ptr       (ptr),
        .wrap_next (wrap_next)
    );

    // Out-of-range indices fall through to zero rather than reading past the bus.
    function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] data,
                                          input logic [SEL_W-1:0] idx);
        pick = '0;
        for (int k = 0; k < N_CH; k++)
            if (int'(idx) == k) pick = data[k*W +: W];
    endfunction

    always_comb begin
        y_d       = y_q;
        ch_d      = ch_q;
        valid_d   = 1'b0;
        sel_err_d = sel_err_q;
        wrap_d    = 1'b0;
        if (bus.en) begin
            valid_d = 1'b1;
            wrap_d  = wrap_next;
            if (bus.mode == MODE_AUTO) begin
                y_d       = pick(bus.i, ptr);
                ch_d      = ptr;
                sel_err_d = 1'b0;
            end else begin
                y_d       = pick(bus.i, bus.s);
                ch_d      = bus.s;
                sel_err_d = (int'(bus.s) >= N_CH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            y_q       <= y_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.ch      = ch_q;
    assign bus.valid   = valid_q;
    assign bus.sel_err = sel_err_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - directed bench over four mux_scan_n configurations
module tb_mux_scan_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mux_scan_n_if #(.N_CH(8), .W(1), .SEL_W(3)) b0 ();
    mux_scan_n_if #(.N_CH(8), .W(8), .SEL_W(3)) b1 ();
    mux_scan_n_if #(.N_CH(5), .W(4), .SEL_W(3)) b2 ();
    mux_scan_n_if #(.N_CH(2), .W(1), .SEL_W(1)) b3 ();

    mux_scan_n #(.N_CH(8), .W(1), .DWELL(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mux_scan_n #(.N_CH(8), .W(8), .DWELL(3)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mux_scan_n #(.N_CH(5), .W(4), .DWELL(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    mux_scan_n #(.N_CH(2), .W(1), .DWELL(1)) u3 (.clk(clk), .rst(rst), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] man_exp [8] = '{0, 1, 1, 0, 0, 1, 0, 1};
    int exp_ch;

    initial begin
        b0.i = 8'b1010_0110; b0.s = '0; b0.mode = 1'b0; b0.en = 1'b0;
        b1.i = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        b1.s = '0; b1.mode = 1'b0; b1.en = 1'b0;
        b2.i = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1}; b2.s = '0; b2.mode = 1'b0; b2.en = 1'b0;
        b3.i = 2'b10; b3.s = '0; b3.mode = 1'b0; b3.en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_y", 32'(b0.y), 0);
        chk("rst_ch", 32'(b0.ch), 0);
        chk("rst_valid", 32'(b0.valid), 0);
        chk("rst_sel_err", 32'(b0.sel_err), 0);
        chk("rst_wrap", 32'(b0.wrap), 0);

        // manual sweep, W=1
        b0.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b0.s = 3'(k);
            tick();
            chk($sformatf("man_y%0d", k), 32'(b0.y), 32'(man_exp[k]));
            chk($sformatf("man_ch%0d", k), 32'(b0.ch), k);
            chk("man_valid", 32'(b0.valid), 1);
            chk("man_sel_err", 32'(b0.sel_err), 0);
        end
        b0.s = 3'd5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_y", 32'(b0.y), 0);
        chk("midrst_ch", 32'(b0.ch), 0);
        chk("midrst_valid", 32'(b0.valid), 0);
        b0.en = 1'b0;

        // auto scan, DWELL=3, wrap rides with the last channel-7 sample
        b1.mode = 1'b1; b1.en = 1'b1;
        for (int c = 0; c < 27; c++) begin
            tick();
            exp_ch = (c / 3) % 8;
            chk($sformatf("auto_ch%0d", c), 32'(b1.ch), exp_ch);
            chk($sformatf("auto_y%0d", c), 32'(b1.y), 32'h10 + exp_ch);
            chk($sformatf("auto_wrap%0d", c), 32'(b1.wrap), (c % 24 == 23) ? 1 : 0);
        end

        // mode switching
        pulse_rst();
        for (int c = 0; c < 16; c++) tick();
        chk("msw_at5", 32'(b1.ch), 5);
        b1.mode = 1'b0; b1.s = 3'd2;
        tick();
        chk("msw_man_y", 32'(b1.y), 32'h12);
        chk("msw_man_ch", 32'(b1.ch), 2);
        b1.mode = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("msw_back_ch%0d", c), 32'(b1.ch), (c < 3) ? 0 : 1);
            chk($sformatf("msw_back_y%0d", c), 32'(b1.y), (c < 3) ? 32'h10 : 32'h11);
        end
        b1.en = 1'b0; b1.mode = 1'b0;

        // enable gap mid-dwell, DWELL=4
        pulse_rst();
        b0.i = 8'b0000_1000; b0.mode = 1'b1; b0.en = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        chk("gap_pre_ch", 32'(b0.ch), 3);
        b0.en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("gap_ch%0d", c), 32'(b0.ch), 3);
            chk($sformatf("gap_y%0d", c), 32'(b0.y), 1);
            chk($sformatf("gap_valid%0d", c), 32'(b0.valid), 0);
        end
        b0.en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("gap_post_ch%0d", c), 32'(b0.ch), (c < 2) ? 3 : 4);
            chk($sformatf("gap_post_y%0d", c), 32'(b0.y), (c < 2) ? 1 : 0);
            chk("gap_post_valid", 32'(b0.valid), 1);
        end
        b0.en = 1'b0; b0.mode = 1'b0;

        // N_CH=5: out-of-range manual selects, then auto scan
        b2.en = 1'b1;
        b2.s = 3'd4;
        tick();
        chk("np2_s4_y", 32'(b2.y), 5);
        chk("np2_s4_err", 32'(b2.sel_err), 0);
        for (int k = 5; k < 8; k++) begin
            b2.s = 3'(k);
            tick();
            chk($sformatf("np2_y%0d", k), 32'(b2.y), 0);
            chk($sformatf("np2_ch%0d", k), 32'(b2.ch), k);
            chk($sformatf("np2_err%0d", k), 32'(b2.sel_err), 1);
        end
        b2.en = 1'b0;
        tick();
        chk("np2_err_hold", 32'(b2.sel_err), 1);
        chk("np2_gap_valid", 32'(b2.valid), 0);
        b2.en = 1'b1; b2.mode = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            exp_ch = (c / 2) % 5;
            chk($sformatf("np2_auto_ch%0d", c), 32'(b2.ch), exp_ch);
            chk($sformatf("np2_auto_y%0d", c), 32'(b2.y), exp_ch + 1);
            chk($sformatf("np2_auto_wrap%0d", c), 32'(b2.wrap), (c % 10 == 9) ? 1 : 0);
            chk("np2_auto_err", 32'(b2.sel_err), 0);
        end
        b2.en = 1'b0;

        // DWELL=1, N_CH=2
        b3.mode = 1'b1; b3.en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("d1_ch%0d", c), 32'(b3.ch), c % 2);
            chk($sformatf("d1_y%0d", c), 32'(b3.y), c % 2);
            chk($sformatf("d1_wrap%0d", c), 32'(b3.wrap), c % 2);
        end
        b3.en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
